seq_detector_param: RTL and testbench

Parametrised, runtime-programmable serial bit-sequence detector (Mealy-style, registered output).
- Detects any pattern of 1..MAX_LEN bits on a 1-bit serial input, selected at runtime via a config load; successor to the fixed 4-bit detectors in the sequence-detector library.
- Supports overlapping or non-overlapping detection, input qualification (din_valid) and a configuration-error flag.
- Sits between a serial deserialiser/bit source and control logic that consumes the match pulse.

---
 rtl/seq_detector_param.sv | 139 +++++++++++++
 tb/tb_seq_detector_param.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-programmable serial bit-sequence detector (1..MAX_LEN bits).
// Latency: y is registered and rises on the same edge that samples the completing bit.
// Backpressure: none; din is only sampled when din_valid is high, and cfg_load wins over din.
// Optional match counter is enabled by defining SEQDET_MATCH_COUNT_EN.
module seq_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               din,
  input  logic               din_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap,
  input  logic               clr_cnt,
  output logic               y,
  output logic               armed,
  output logic               cfg_err,
  output logic [CNT_W-1:0]   match_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  state_t             state, state_next;
  logic [MAX_LEN-1:0] history, history_next, history_shift;
  logic [LEN_W-1:0]   fill, fill_next, fill_adv;
  logic [MAX_LEN-1:0] pat_l;
  logic [LEN_W-1:0]   len_l;
  logic               ovl_l;
  logic [MAX_LEN-1:0] len_mask;
  logic               cfg_legal;
  logic               sample;
  logic               match;

  // Config legality: pattern length must be within 1..MAX_LEN
  always_comb begin
    cfg_legal = (pat_len != '0) && (pat_len <= LEN_W'(MAX_LEN));
  end

  // Mask selecting the low len_l bits used in the comparison
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < len_l);
    end
  end

  // Datapath next-state: shift history, advance fill, evaluate match on next-state values
  always_comb begin
    history_shift = {history[MAX_LEN-2:0], din};
    fill_adv      = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
    sample        = (state == ARMED) && din_valid && !cfg_load;
    match         = sample && (fill_adv >= len_l) &&
                    ((history_shift & len_mask) == (pat_l & len_mask));
    history_next  = history;
    fill_next     = fill;
    if (cfg_load) begin
      history_next = '0;
      fill_next    = '0;
    end else if (sample) begin
      history_next = history_shift;
      // Non-overlapping mode: the matched bits may not seed the next match
      fill_next    = (match && !ovl_l) ? '0 : fill_adv;
    end
  end

  // FSM next-state: any cfg_load re-decides ARMED vs IDLE from pat_len legality
  always_comb begin
    state_next = state;
    if (cfg_load) begin
      state_next = cfg_legal ? ARMED : IDLE;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // History, fill, latched config, match pulse and error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      history <= '0;
      fill    <= '0;
      pat_l   <= '0;
      len_l   <= '0;
      ovl_l   <= 1'b0;
      y       <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      history <= history_next;
      fill    <= fill_next;
      y       <= match;
      if (cfg_load) begin
        cfg_err <= !cfg_legal;
        if (cfg_legal) begin
          pat_l <= pattern;
          len_l <= pat_len;
          ovl_l <= overlap;
        end
      end
    end
  end

  assign armed = (state == ARMED);

`ifdef SEQDET_MATCH_COUNT_EN
  logic [CNT_W-1:0] cnt;

  // Saturating match counter; clear (clr_cnt or cfg_load) beats a coincident increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr_cnt || cfg_load) begin
      cnt <= '0;
    end else if (match && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign match_cnt = cnt;
`else
  logic unused_clr_cnt;

  assign unused_clr_cnt = clr_cnt;
  assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed self-checking bench for seq_detector_param (MAX_LEN=8, CNT_W=2).
module tb_seq_detector_param;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int CNT_W   = 2;
`ifdef SEQDET_MATCH_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic               clk;
  logic               reset;
  logic               din;
  logic               din_valid;
  logic               cfg_load;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   pat_len;
  logic               overlap;
  logic               clr_cnt;
  logic               y;
  logic               armed;
  logic               cfg_err;
  logic [CNT_W-1:0]   match_cnt;

  int checks   = 0;
  int failures = 0;

  seq_detector_param #(
    .MAX_LEN(MAX_LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .din      (din),
    .din_valid(din_valid),
    .cfg_load (cfg_load),
    .pattern  (pattern),
    .pat_len  (pat_len),
    .overlap  (overlap),
    .clr_cnt  (clr_cnt),
    .y        (y),
    .armed    (armed),
    .cfg_err  (cfg_err),
    .match_cnt(match_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected counter value depends on whether the counter is built
  function automatic logic [31:0] ecnt(input int n);
    return CNT_ON ? 32'(n) : 32'd0;
  endfunction

  task automatic do_cfg(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input logic o);
    cfg_load  = 1'b1;
    pattern   = p;
    pat_len   = l;
    overlap   = o;
    din_valid = 1'b1;
    din       = 1'b1;
    @(posedge clk); #1;
    cfg_load  = 1'b0;
    din_valid = 1'b0;
  endtask

  task automatic send(input logic d);
    din       = d;
    din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
  endtask

  task automatic gap();
    din_valid = 1'b0;
    din       = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [6:0] s1;
    logic [6:0] e1;
    logic [6:0] e2;
    logic [7:0] s3;
    reset = 1'b1; din = 1'b0; din_valid = 1'b0; cfg_load = 1'b0;
    pattern = '0; pat_len = '0; overlap = 1'b0; clr_cnt = 1'b0;
    #2;
    check("rst_y", y, 0);
    check("rst_armed", armed, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_cnt", match_cnt, 0);
    #10 reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_armed", armed, 0);

    // Overlapping 1001 on stream 1001001: matches after bits 4 and 7
    do_cfg(8'b0000_1001, 4'd4, 1'b1);
    check("cfg_armed", armed, 1);
    check("cfg_y", y, 0);
    s1 = 7'b1001001; e1 = 7'b0001001;
    for (int i = 0; i < 7; i++) begin
      send(s1[6-i]);
      check($sformatf("ovl_y_bit%0d", i + 1), y, e1[6-i]);
    end
    check("ovl_cnt", match_cnt, ecnt(2));
    gap();
    check("ovl_gap_y", y, 0);

    // Non-overlapping: fill restarts so bit 7 does not match
    do_cfg(8'b0000_1001, 4'd4, 1'b0);
    check("novl_cnt_cleared", match_cnt, 0);
    e2 = 7'b0001000;
    for (int i = 0; i < 7; i++) begin
      send(s1[6-i]);
      check($sformatf("novl_y_bit%0d", i + 1), y, e2[6-i]);
    end
    check("novl_cnt", match_cnt, ecnt(1));

    // Full-length pattern with a 3-cycle qualification gap after bit 3
    do_cfg(8'b1011_0011, 4'd8, 1'b1);
    s3 = 8'b1011_0011;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        for (int g = 0; g < 3; g++) begin
          gap();
          check($sformatf("full_gap%0d_y", g), y, 0);
        end
      end
      send(s3[7-i]);
      check($sformatf("full_y_bit%0d", i + 1), y, (i == 7) ? 1 : 0);
    end

    // Illegal lengths from ARMED and IDLE, then a legal 111 config
    do_cfg(8'b0000_0111, 4'd0, 1'b1);
    check("len0_armed", armed, 0);
    check("len0_err", cfg_err, 1);
    send(1'b1); send(1'b1);
    check("len0_y", y, 0);
    do_cfg(8'b0000_0111, 4'd9, 1'b1);
    check("len9_armed", armed, 0);
    check("len9_err", cfg_err, 1);
    send(1'b1);
    check("len9_y", y, 0);
    do_cfg(8'b0000_0111, 4'd3, 1'b1);
    check("len3_err", cfg_err, 0);
    check("len3_armed", armed, 1);
    send(1'b1); check("ones_y1", y, 0);
    send(1'b1); check("ones_y2", y, 0);
    send(1'b1); check("ones_y3", y, 1);
    send(1'b1); check("ones_y4", y, 1);
    gap();      check("ones_gap_y", y, 0);

    // cfg_load coincident with din: din discarded, history cleared
    send(1'b1);
    do_cfg(8'b0000_0111, 4'd3, 1'b1);
    check("cfg_prio_y", y, 0);
    send(1'b1); send(1'b1);
    check("cfg_prio_y2", y, 0);
    send(1'b1);
    check("cfg_prio_y3", y, 1);

    // Asynchronous reset between edges aborts a partial 1001
    do_cfg(8'b0000_1001, 4'd4, 1'b1);
    send(1'b1); send(1'b0); send(1'b0);
    #2 reset = 1'b1;
    #1;
    check("arst_y", y, 0);
    check("arst_armed", armed, 0);
    check("arst_err", cfg_err, 0);
    check("arst_cnt", match_cnt, 0);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    send(1'b1);
    check("arst_after_y", y, 0);
    check("arst_after_armed", armed, 0);

    // Length-1 pattern: every qualifying matching bit pulses; counter saturates
    do_cfg(8'b0000_0000, 4'd1, 1'b0);
    send(1'b0); check("len1_z_y", y, 1);
    send(1'b1); check("len1_o_y", y, 0);
    send(1'b0); check("len1_z2_y", y, 1);
    do_cfg(8'b0000_0001, 4'd1, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      send(1'b1);
      check($sformatf("sat_y%0d", i), y, 1);
      check($sformatf("sat_cnt%0d", i), match_cnt, ecnt((i > 3) ? 3 : i));
    end
    clr_cnt = 1'b1;
    send(1'b1);
    clr_cnt = 1'b0;
    check("clr_match_y", y, 1);
    check("clr_match_cnt", match_cnt, 0);
    send(1'b1);
    check("after_clr_cnt", match_cnt, ecnt(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
